// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: arbitration state and port indices.
// Lock states are only reachable with DMEM_ARB_LOCK_EN defined.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational one-hot grant selection.
// Round-robin in ARB_IDLE; a locked state only serves its owner.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_prio,
  input  arb_state_t i_state,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_state)
      ARB_LOCK0: o_gnt[0] = i_req0;
      ARB_LOCK1: o_gnt[1] = i_req1;
      default: begin
        if (i_req0 && i_req1) begin
          if (i_prio == ARB_PORT1) o_gnt = 2'b10;
          else                     o_gnt = 2'b01;
        end else begin
          o_gnt = {i_req1, i_req0};
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter for the 8x256 data memory.
// Optional bus lock for RMW sequences under `DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic         i_we0,
  input  logic         i_we1,
  input  logic [A-1:0] i_addr0,
  input  logic [A-1:0] i_addr1,
  input  logic [W-1:0] i_wdata0,
  input  logic [W-1:0] i_wdata1,
  input  logic         i_lock0,
  input  logic         i_lock1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_rvalid0,
  output logic         o_rvalid1,
  output logic [W-1:0] o_rdata0,
  output logic [W-1:0] o_rdata1,
  output logic         o_mem_write_en,
  output logic [A-1:0] o_mem_address,
  output logic [W-1:0] o_mem_data_in,
  input  logic [W-1:0] i_mem_data_out
);

  logic       r_prio;
  arb_state_t w_state;
  logic [1:0] w_pick;
  logic [1:0] w_gnt;
  logic       w_rd0;
  logic       w_rd1;

  dmem_arb_pick u_pick (
    .i_req0  (i_req0),
    .i_req1  (i_req1),
    .i_prio  (r_prio),
    .i_state (w_state),
    .o_gnt   (w_pick)
  );

  // Gating with reset kills a write that is mid-grant when reset hits.
  assign w_gnt  = w_pick & {2{i_rst_n}};
  assign o_gnt0 = w_gnt[0];
  assign o_gnt1 = w_gnt[1];

`ifdef DMEM_ARB_LOCK_EN
  arb_state_t r_state;
  arb_state_t w_state_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ARB_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_gnt[0] && i_lock0)      w_state_nxt = ARB_LOCK0;
        else if (w_gnt[1] && i_lock1) w_state_nxt = ARB_LOCK1;
      end
      ARB_LOCK0: if (!i_lock0) w_state_nxt = ARB_IDLE;
      ARB_LOCK1: if (!i_lock1) w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_state = r_state;
`else
  logic w_lock_unused;

  assign w_lock_unused = i_lock0 ^ i_lock1;
  assign w_state       = ARB_IDLE;
`endif

  // Pointer moves only on idle-state grants; a lock freezes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= ARB_PORT0;
    end else if (w_state == ARB_IDLE) begin
      if (w_gnt[0])      r_prio <= ARB_PORT1;
      else if (w_gnt[1]) r_prio <= ARB_PORT0;
    end
  end

  always_comb begin
    o_mem_write_en = 1'b0;
    o_mem_address  = '0;
    o_mem_data_in  = '0;
    if (w_gnt[0]) begin
      o_mem_write_en = i_we0;
      o_mem_address  = i_addr0;
      o_mem_data_in  = i_wdata0;
    end else if (w_gnt[1]) begin
      o_mem_write_en = i_we1;
      o_mem_address  = i_addr1;
      o_mem_data_in  = i_wdata1;
    end
  end

  assign w_rd0 = w_gnt[0] & ~i_we0;
  assign w_rd1 = w_gnt[1] & ~i_we1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      o_rvalid0 <= w_rd0;
      o_rvalid1 <= w_rd1;
      if (w_rd0) o_rdata0 <= i_mem_data_out;
      if (w_rd1) o_rdata1 <= i_mem_data_out;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-ported 8x256 data memory. Shares its one address/data path between requester 0 (core load/store unit) and requester 1 (DMA / memory-fill engine). Grants at most one access per cycle, round-robin, with an optional bus lock for atomic read-modify-write sequences. Registers read data back to the winning requester.

## Interface
- W, 8, data width; matches memory word width
- A, 8, address width; memory depth 2**A
- Clk  input  1  single clock, all state on posedge
- Reset  input  1  asynchronous, active-low; clears all state immediately when low
- Req0, Req1  input  1  access request; held until the matching Gnt is seen
- We0, We1  input  1  1 = write, 0 = read; valid while Req high
- Addr0, Addr1  input  A  access address
- Wdata0, Wdata1  input  W  write data
- Lock0, Lock1  input  1  hold arbitration for this port after its grant
- Gnt0, Gnt1  output  1  combinational grant; the access is performed in this cycle
- Rvalid0, Rvalid1  output  1  registered read-data valid, one cycle after a read grant
- Rdata0, Rdata1  output  W  registered read data
- MemWriteEn  output  1  to memory WriteEn
- MemAddress  output  A  to memory DataAddress
- MemDataIn  output  W  to memory DataIn
- MemDataOut  input  W  from memory DataOut (combinational read)

## Operation
- State: FSM `{ARB_IDLE, ARB_LOCK0, ARB_LOCK1}` and 1-bit round-robin pointer `Prio`.
- ARB_IDLE, one Req high: grant that port. Both Req high: grant port `Prio`.
- After any grant to port k: `Prio <= ~k`. In a locked state, `Prio` is left unchanged.
- ARB_LOCKk: only port k can be granted. The other port's Req is ignored, and its Gnt stays 0.
- Entering a lock: in ARB_IDLE, port k is granted with Lockk=1, so the next state is ARB_LOCKk.
- Leaving a lock: in ARB_LOCKk, Lockk=0 at the posedge returns the FSM to ARB_IDLE, whether or not Reqk is high. Lockk without a grant in ARB_IDLE has no effect.
- Mux: MemAddress = Addr of the granted port. MemDataIn = Wdata of the granted port. MemWriteEn = Gnt & We of the granted port.
- With no grant: MemWriteEn=0, MemAddress=0, MemDataIn=0.
- Read grant to port k: at the posedge, Rdatak <= MemDataOut and Rvalidk <= 1.
- Otherwise Rvalidk <= 0 and Rdatak holds its last value. A write grant never raises Rvalid.
- Gnt0 & Gnt1 is never 1.

## Timing
- Grant latency 0: Gnt is asserted in the same cycle as Req when the port wins.
- Write commits at the posedge that ends the grant cycle.
- Read data latency 1: Rvalid and Rdata are valid in the cycle after Gnt, for exactly one cycle per grant.
- Back-to-back: one port may be granted every cycle.
  - Both requesting continuously: strict alternation 0,1,0,1… starting from `Prio`.
- A requester drops Req, or changes Addr/We/Wdata, only after the cycle in which it saw Gnt.
- Reset low, at any time including mid-lock:
  - FSM = ARB_IDLE, Prio = 0
  - Rvalid0 = Rvalid1 = 0, Rdata0 = Rdata1 = 0
  - Gnt0 = Gnt1 = 0, MemWriteEn = 0
  - A write in its grant cycle is suppressed.
- First cycle after reset release: normal arbitration.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: lock behaviour as above.
- Not defined: Lock0/Lock1 ignored, FSM removed (always ARB_IDLE), pure round-robin.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum
  - port-index constants `ARB_PORT0 = 1'b0`, `ARB_PORT1 = 1'b1`
- Sub-module `dmem_arb_pick` (combinational):
  - inputs: Req0, Req1, Prio, state
  - outputs: one-hot grant
- Top level holds the FSM, `Prio`, the memory mux and the read-return registers.

## Test plan
- Reset, then Req0 read Addr0=0x10 with memory[0x10]=0x5A -> Gnt0 same cycle, next cycle Rvalid0=1, Rdata0=0x5A, Rvalid1=0.
- Req0 and Req1 held for 4 cycles after reset (both reads) -> grants 0,1,0,1; each Rvalid pulses one cycle after its grant.
- Req1 write 0xC3 to 0x20, then Req0 read 0x20 -> Rdata0=0xC3; Rvalid1 never asserted.
- With `DMEM_ARB_LOCK_EN`:
  - Req0+Lock0 read 0x30, then write 0x30, Req1 held throughout -> Gnt1=0 until the cycle after Lock0 drops, then Gnt1=1.
  - Without the macro: same stimulus -> alternating grants.
- Reset asserted mid-lock while Req0 writes 0xFF to 0x40 -> write suppressed (memory[0x40] unchanged), all outputs 0, FSM in ARB_IDLE, first grant after release goes to port 0 when both request.
